uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `uart` transmitter between `N_REQ` byte-producing requesters. It sits between the requesters and the `uart` TX inputs (`tx_data_valid`, `tx_data`) and sequences one byte at a time. It uses the UART's `tx_busy` to know when a frame has started and finished. It also flags a transmitter that never starts a frame.

---
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// Optional UART_TX_ARBITER_LOCK_EN adds i_req_lock to keep multi-byte messages contiguous.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned START_TIMEOUT = 64,
   localparam int unsigned IW           = $clog2(N_REQ)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [N_REQ*8-1:0] i_req_data,
`ifdef UART_TX_ARBITER_LOCK_EN
   input  logic [N_REQ-1:0]   i_req_lock,
`endif
   output logic [N_REQ-1:0]   o_req_ready,
   output logic               o_tx_data_valid,
   output logic [7:0]         o_tx_data,
   input  logic               i_tx_busy,
   output logic [IW-1:0]      o_grant_id,
   output logic               o_arb_busy,
   output logic               o_start_err
);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitStart, StWaitDone} state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [IW-1:0]      r_last;
   logic [7:0]         r_cnt;
   logic [N_REQ-1:0]   r_req_ready;
   logic               r_tx_valid;
   logic [7:0]         r_tx_data;
   logic [IW-1:0]      r_grant_id;
   logic               r_arb_busy;
   logic               r_start_err;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic               r_lock_ok;
`endif

   logic [IW-1:0]      w_win;
   logic [IW-1:0]      w_sel;
   logic               w_found;
   logic               w_issue;
   logic               w_timeout;
   logic [7:0]         w_cnt_inc;
   logic [N_REQ-1:0]   w_onehot;

   // First valid requester searching upward from last+1 with wrap-around
   always_comb begin
      w_win   = r_last;
      w_sel   = '0;
      w_found = 1'b0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         w_sel = IW'((32'(r_last) + i) % N_REQ);
         if (!w_found && i_req_valid[w_sel]) begin
            w_found = 1'b1;
            w_win   = w_sel;
         end
      end
`ifdef UART_TX_ARBITER_LOCK_EN
      if (r_lock_ok && i_req_lock[r_last] && i_req_valid[r_last]) begin
         w_found = 1'b1;
         w_win   = r_last;
      end
`endif
   end

   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_found && !i_tx_busy) begin
               w_issue     = 1'b1;
               w_state_nxt = StIssue;
            end
         end
         StIssue: w_state_nxt = StWaitStart;
         StWaitStart: begin
            if (i_tx_busy) begin
               w_state_nxt = StWaitDone;
            end else if (w_cnt_inc == 8'(START_TIMEOUT)) begin
               w_timeout   = 1'b1;
               w_state_nxt = StIdle;
            end
         end
         StWaitDone: begin
            if (!i_tx_busy) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_last      <= IW'(N_REQ - 1);
         r_cnt       <= 8'h00;
         r_req_ready <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_data   <= 8'h00;
         r_grant_id  <= '0;
         r_arb_busy  <= 1'b0;
         r_start_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tx_valid  <= w_issue;
         r_req_ready <= w_issue ? w_onehot : '0;
         r_start_err <= w_timeout;
         r_arb_busy  <= (w_state_nxt != StIdle);
         if (w_issue) begin
            r_tx_data  <= i_req_data[{w_win, 3'b000} +: 8];
            r_grant_id <= w_win;
            r_last     <= w_win;
         end
         if (r_state == StIssue) begin
            r_cnt <= 8'h00;
         end else if (r_state == StWaitStart && !i_tx_busy) begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

`ifdef UART_TX_ARBITER_LOCK_EN
   // Lock priority only applies after a frame that actually completed
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lock_ok <= 1'b0;
      end else if (r_state == StWaitDone && w_state_nxt == StIdle) begin
         r_lock_ok <= 1'b1;
      end else if (w_timeout) begin
         r_lock_ok <= 1'b0;
      end
   end
`endif

   assign o_req_ready     = r_req_ready;
   assign o_tx_data_valid = r_tx_valid;
   assign o_tx_data       = r_tx_data;
   assign o_grant_id      = r_grant_id;
   assign o_arb_busy      = r_arb_busy;
   assign o_start_err     = r_start_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART busy model.
module tb_uart_tx_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned TO    = 8;
   localparam int unsigned FRAME = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic [3:0]  req_lock;
`endif
   logic [3:0]  req_ready;
   logic        tx_data_valid;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        start_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ         (N),
      .START_TIMEOUT (TO)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_req_valid     (req_valid),
      .i_req_data      (req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
      .i_req_lock      (req_lock),
`endif
      .o_req_ready     (req_ready),
      .o_tx_data_valid (tx_data_valid),
      .o_tx_data       (tx_data),
      .i_tx_busy       (tx_busy),
      .o_grant_id      (grant_id),
      .o_arb_busy      (arb_busy),
      .o_start_err     (start_err)
   );

   // UART model: busy for FRAME cycles starting the cycle after a start pulse
   logic        uart_en;
   logic        ext_busy;
   int unsigned busy_cnt = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_data_valid && uart_en) busy_cnt <= FRAME;
      else if (busy_cnt != 0)       busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = ext_busy | (busy_cnt != 0);

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] gid;
      logic [3:0] rdy;
   } exp_t;

   exp_t exp_q[$];
   int   err_q[$];
   int   passed = 0;
   int   total  = 0;
   int   issues = 0;
   int   errs   = 0;
   int   n_exp  = 0;
   int   last_issue_cyc = 0;
   logic prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic push_exp(input logic [7:0] d, input logic [1:0] g, input logic [3:0] r);
      exp_t e;
      e.data = d;
      e.gid  = g;
      e.rdy  = r;
      exp_q.push_back(e);
      n_exp++;
   endtask

   // Monitor: pops an expectation for each start pulse and each start_err pulse
   initial begin
      exp_t e;
      int   off;
      forever begin
         @(negedge clk);
         if (rst_n && tx_data_valid) begin
            issues++;
            last_issue_cyc = cyc;
            check("issue_while_busy", 32'(prev_busy), 32'd0);
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_issue: got byte %02h grant %0d, expected none",
                        tx_data, grant_id);
            end else begin
               e = exp_q.pop_front();
               check("tx_data", 32'(tx_data), 32'(e.data));
               check("grant_id", 32'(grant_id), 32'(e.gid));
               check("req_ready", 32'(req_ready), 32'(e.rdy));
            end
         end
         if (rst_n && start_err) begin
            errs++;
            if (err_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_start_err: got pulse at cycle %0d, expected none", cyc);
            end else begin
               off = err_q.pop_front();
               check("start_err_delay", 32'(cyc - last_issue_cyc), 32'(off));
            end
         end
         prev_busy = tx_busy;
      end
   end

   task automatic wait_issues(input int target, input string name);
      int n = 0;
      while (issues < target && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(issues), 32'(target));
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((arb_busy || tx_busy) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(arb_busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_tx_valid"},  32'(tx_data_valid), 32'd0);
      check({tag, "_tx_data"},   32'(tx_data), 32'd0);
      check({tag, "_grant_id"},  32'(grant_id), 32'd0);
      check({tag, "_arb_busy"},  32'(arb_busy), 32'd0);
      check({tag, "_start_err"}, 32'(start_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall_cyc;
      int n;
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_data  = 32'h0;
      uart_en   = 1'b1;
      ext_busy  = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
      req_lock  = 4'b0000;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("idle");

      // All four valid from reset: 0,1,2,3,0
      req_data  = 32'hAA55FF00;
      req_valid = 4'b1111;
      push_exp(8'h00, 2'd0, 4'b0001);
      push_exp(8'hFF, 2'd1, 4'b0010);
      push_exp(8'h55, 2'd2, 4'b0100);
      push_exp(8'hAA, 2'd3, 4'b1000);
      push_exp(8'h00, 2'd0, 4'b0001);
      wait_issues(n_exp, "rr_issues");
      req_valid = 4'b0000;
      wait_idle("rr_idle");

      // Single requester 2
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      push_exp(8'hA5, 2'd2, 4'b0100);
      wait_issues(n_exp, "single_issue");
      req_valid = 4'b0000;
      wait_idle("single_idle");
      check("tx_data_held", 32'(tx_data), 32'hA5);

      // Start timeout: UART never goes busy
      uart_en = 1'b0;
      req_data[15:8] = 8'h3C;
      req_valid = 4'b0010;
      push_exp(8'h3C, 2'd1, 4'b0010);
      err_q.push_back(TO + 1);
      wait_issues(n_exp, "to_issue");
      req_valid = 4'b0000;
      n = 0;
      while (errs < 1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("to_err_seen", 32'(errs), 32'd1);
      wait_idle("to_idle");
      uart_en = 1'b1;
      req_data[31:24] = 8'h77;
      req_valid = 4'b1000;
      push_exp(8'h77, 2'd3, 4'b1000);
      wait_issues(n_exp, "after_to_issue");
      req_valid = 4'b0000;
      wait_idle("after_to_idle");

      // External busy blocks issue; issue one cycle after the fall
      ext_busy = 1'b1;
      req_data[15:8] = 8'h5A;
      req_valid = 4'b0010;
      push_exp(8'h5A, 2'd1, 4'b0010);
      repeat (10) @(posedge clk);
      #1;
      check("busy_hold_no_issue", 32'(issues), 32'(n_exp - 1));
      ext_busy = 1'b0;
      fall_cyc = cyc;
      wait_issues(n_exp, "busy_fall_issue");
      check("issue_after_fall", 32'(last_issue_cyc - fall_cyc), 32'd1);
      req_valid = 4'b0000;
      wait_idle("busy_idle");

`ifdef UART_TX_ARBITER_LOCK_EN
      // Locked requester 1 keeps the grant over requester 3 for three bytes
      req_data[31:24] = 8'h33;
      req_data[15:8]  = 8'h10;
      req_lock  = 4'b0010;
      req_valid = 4'b0010;
      push_exp(8'h10, 2'd1, 4'b0010);
      wait_issues(n_exp, "lock_b0");
      req_data[15:8] = 8'h11;
      req_valid = 4'b1010;
      push_exp(8'h11, 2'd1, 4'b0010);
      wait_issues(n_exp, "lock_b1");
      req_data[15:8] = 8'h12;
      push_exp(8'h12, 2'd1, 4'b0010);
      wait_issues(n_exp, "lock_b2");
      req_valid = 4'b1000;
      req_lock  = 4'b0000;
      push_exp(8'h33, 2'd3, 4'b1000);
      wait_issues(n_exp, "lock_b3");
      req_valid = 4'b0000;
      wait_idle("lock_idle");
`endif

      // Reset during WAIT_DONE, then requester 0 has first priority
      req_data[23:16] = 8'h11;
      req_valid = 4'b0100;
      push_exp(8'h11, 2'd2, 4'b0100);
      wait_issues(n_exp, "wd_issue");
      req_valid = 4'b0000;
      repeat (4) @(posedge clk);
      #1;
      check("wd_reached", 32'({arb_busy, tx_busy}), 32'b11);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_data[7:0]   = 8'hC3;
      req_data[31:24] = 8'h3F;
      req_valid = 4'b1001;
      push_exp(8'hC3, 2'd0, 4'b0001);
      wait_issues(n_exp, "post_rst_first");
      req_valid = 4'b1000;
      push_exp(8'h3F, 2'd3, 4'b1000);
      wait_issues(n_exp, "post_rst_second");
      req_valid = 4'b0000;
      wait_idle("final_idle");

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("err_q_empty", 32'(err_q.size()), 32'd0);
      check("start_err_count", 32'(errs), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
